// File: rtl/urna_tally_n_pkg.sv
// Shared encodings for the urna vote-tally core: FSM states, vote status codes,
// key event priority and the empty-digit marker.
package urna_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_RESULTS = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        VS_NONE  = 2'b00,
        VS_CAND  = 2'b01,
        VS_NULL  = 2'b10,
        VS_BLANK = 2'b11
    } vote_status_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CANCEL,
        EV_BLANK,
        EV_FINISH,
        EV_VALID
    } key_event_t;

    localparam logic [3:0] EMPTY_DIGIT = 4'hF;
    localparam logic [3:0] MAX_DIGIT   = 4'd9;

    // Key pulse vector order is {valid, cancel, blank, finish}; only the
    // highest-priority event of a cycle survives.
    function automatic key_event_t pick_event(input logic [3:0] pulses);
        if (pulses[2])      return EV_CANCEL;
        else if (pulses[1]) return EV_BLANK;
        else if (pulses[0]) return EV_FINISH;
        else if (pulses[3]) return EV_VALID;
        else                return EV_NONE;
    endfunction

endpackage

// File: rtl/urna_tally_n_key_edge.sv
// Registers a bank of level keys and emits a one-cycle pulse on each rising edge,
// so a held key produces exactly one action.
module urna_key_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] keys,
    output logic [WIDTH-1:0] pulses
);

    logic [WIDTH-1:0] key_r;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) key_r <= '0;
        else          key_r <= keys;
    end

    assign pulses = keys & ~key_r;

endmodule

// File: rtl/urna_tally_n.sv
// Parametrised ballot-box tally core: BCD code entry, candidate matching with
// optional 0/1 swap, saturating per-slot counters and a stepped results readout.
module urna_tally_n
    import urna_pkg::*;
#(
    parameter int                      NUM_CAND   = 2,
    parameter int                      DIGITS     = 2,
    parameter int                      CNT_W      = 8,
    parameter logic [16*NUM_CAND-1:0]  CAND_CODES = {16'h22, 16'h13}
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [3:0]                        digit,
    input  logic                              valid,
    input  logic                              cancel,
    input  logic                              blank,
    input  logic                              finish,
    input  logic                              swap,
    output logic [2:0]                        state,
    output logic [1:0]                        vote_status,
    output logic [4*DIGITS-1:0]               entry_bcd,
    output logic [$clog2(NUM_CAND+2)-1:0]     res_sel,
    output logic [CNT_W-1:0]                  res_count,
    output logic [CNT_W*(NUM_CAND+2)-1:0]     counts,
    output logic                              sat
);

    localparam int NSLOT = NUM_CAND + 2;
    localparam int IDX_W = $clog2(NSLOT);
    localparam int EW    = 4 * DIGITS;

    localparam logic [IDX_W-1:0] NULL_IDX  = IDX_W'(NUM_CAND);
    localparam logic [IDX_W-1:0] BLANK_IDX = IDX_W'(NUM_CAND + 1);
    localparam logic [2:0]       DIG_FULL  = 3'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [EW-1:0]    ENTRY_CLR = {DIGITS{EMPTY_DIGIT}};

    // ------------------------------------------------------------------
    // Key edge detection and event priority
    // ------------------------------------------------------------------
    logic [3:0] pulses;
    key_event_t ev;

    urna_key_edge #(.WIDTH(4)) u_keys (
        .clock   (clock),
        .reset_n (reset_n),
        .keys    ({valid, cancel, blank, finish}),
        .pulses  (pulses)
    );

    assign ev = pick_event(pulses);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             cur_state, nxt_state;
    vote_status_t       vote_reg, vote_nxt;
    logic [EW-1:0]      entry_reg, entry_nxt;
    logic [2:0]         dig_cnt, dig_cnt_nxt;
    logic [IDX_W-1:0]   sel_reg, sel_nxt;
    logic               sat_reg, sat_nxt;
    logic [CNT_W-1:0]   tally     [NSLOT];
    logic [CNT_W-1:0]   tally_nxt [NSLOT];

    // ------------------------------------------------------------------
    // Code compare: one comparator per candidate, lowest index wins
    // ------------------------------------------------------------------
    logic [NUM_CAND-1:0] hit;
    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    target_idx;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cmp
        assign hit[g] = (entry_reg == CAND_CODES[16*g +: EW]);
    end

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Test-mode swap only exchanges the attribution of candidates 0 and 1.
    always_comb begin
        target_idx = NULL_IDX;
        if (hit_any) begin
            if ((NUM_CAND > 1) && swap && (hit_idx < IDX_W'(2)))
                target_idx = hit_idx ^ IDX_W'(1);
            else
                target_idx = hit_idx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    logic             inc_en;
    logic [IDX_W-1:0] inc_idx;
    logic             clear_all;

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        nxt_state   = cur_state;
        vote_nxt    = vote_reg;
        entry_nxt   = entry_reg;
        dig_cnt_nxt = dig_cnt;
        sel_nxt     = sel_reg;
        sat_nxt     = sat_reg;
        tally_nxt   = tally;
        inc_en      = 1'b0;
        inc_idx     = '0;
        clear_all   = 1'b0;

        case (cur_state)
            ST_CLOSED: begin
                if (ev == EV_VALID && start) begin
                    clear_all = 1'b1;
                    nxt_state = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                case (ev)
                    EV_CANCEL: begin
                        entry_nxt   = ENTRY_CLR;
                        dig_cnt_nxt = '0;
                    end
                    EV_BLANK: begin
                        if (dig_cnt == '0) begin
                            inc_en   = 1'b1;
                            inc_idx  = BLANK_IDX;
                            vote_nxt = VS_BLANK;
                        end
                    end
                    EV_FINISH: begin
                        entry_nxt   = ENTRY_CLR;
                        dig_cnt_nxt = '0;
                        sel_nxt     = '0;
                        nxt_state   = ST_RESULTS;
                    end
                    EV_VALID: begin
                        if (digit <= MAX_DIGIT) begin
                            // First digit lands in the most significant nibble.
                            for (int k = 0; k < DIGITS; k++) begin
                                if (k == DIGITS - 1 - int'(dig_cnt))
                                    entry_nxt[4*k +: 4] = digit;
                            end
                            dig_cnt_nxt = dig_cnt + 3'd1;
                            if (dig_cnt + 3'd1 == DIG_FULL)
                                nxt_state = ST_CONFIRM;
                        end
                    end
                    default: ;
                endcase
            end

            ST_CONFIRM: begin
                if (ev == EV_VALID) begin
                    inc_en      = 1'b1;
                    inc_idx     = target_idx;
                    vote_nxt    = hit_any ? VS_CAND : VS_NULL;
                    entry_nxt   = ENTRY_CLR;
                    dig_cnt_nxt = '0;
                    nxt_state   = ST_ENTRY;
                end else if (ev == EV_CANCEL) begin
                    entry_nxt   = ENTRY_CLR;
                    dig_cnt_nxt = '0;
                    nxt_state   = ST_ENTRY;
                end
            end

            ST_RESULTS: begin
                if (ev == EV_FINISH) begin
                    if (sel_reg == BLANK_IDX) begin
                        sel_nxt   = '0;
                        nxt_state = ST_CLOSED;
                    end else begin
                        sel_nxt = sel_reg + IDX_W'(1);
                    end
                end else if (ev == EV_VALID && start) begin
                    clear_all = 1'b1;
                    nxt_state = ST_ENTRY;
                end
            end

            default: nxt_state = ST_CLOSED;
        endcase

        // A new election wipes every counter and the sticky flag at once.
        if (clear_all) begin
            for (int s = 0; s < NSLOT; s++) tally_nxt[s] = '0;
            sat_nxt     = 1'b0;
            vote_nxt    = VS_NONE;
            entry_nxt   = ENTRY_CLR;
            dig_cnt_nxt = '0;
            sel_nxt     = '0;
        end

        if (inc_en) begin
            if (tally[inc_idx] == CNT_MAX) sat_nxt = 1'b1;
            else                           tally_nxt[inc_idx] = tally[inc_idx] + 1'b1;
        end
    end

    // NOTE: the counter array is reset element by element because the results
    // must read zero after reset; it is a small register file, not a RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_CLOSED;
            vote_reg  <= VS_NONE;
            entry_reg <= ENTRY_CLR;
            dig_cnt   <= '0;
            sel_reg   <= '0;
            sat_reg   <= 1'b0;
            for (int s = 0; s < NSLOT; s++) tally[s] <= '0;
        end else begin
            cur_state <= nxt_state;
            vote_reg  <= vote_nxt;
            entry_reg <= entry_nxt;
            dig_cnt   <= dig_cnt_nxt;
            sel_reg   <= sel_nxt;
            sat_reg   <= sat_nxt;
            tally     <= tally_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NSLOT; g++) begin : g_counts
        assign counts[CNT_W*g +: CNT_W] = tally[g];
    end

    assign state       = cur_state;
    assign vote_status = vote_reg;
    assign entry_bcd   = entry_reg;
    assign res_sel     = sel_reg;
    assign sat         = sat_reg;
    assign res_count   = (cur_state == ST_RESULTS) ? tally[sel_reg] : '0;

endmodule

// File: tb/tb_urna_tally_n.sv
// Directed bench for urna_tally_n: a default 8-bit instance plus a 3-bit counter
// instance sharing the same stimulus for the saturation case.
module tb_urna_tally_n;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, valid, cancel, blank, finish, swap;
    logic [3:0]  digit;

    logic [2:0]  state, state_s;
    logic [1:0]  vote_status, vote_status_s;
    logic [7:0]  entry_bcd, entry_bcd_s;
    logic [1:0]  res_sel, res_sel_s;
    logic [7:0]  res_count;
    logic [2:0]  res_count_s;
    logic [31:0] counts;
    logic [11:0] counts_s;
    logic        sat, sat_s;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] K_V = 4'b1000;
    localparam logic [3:0] K_C = 4'b0100;
    localparam logic [3:0] K_B = 4'b0010;
    localparam logic [3:0] K_F = 4'b0001;

    always #5 clock = ~clock;

    urna_tally_n dut (
        .clock(clock), .reset_n(reset_n), .start(start), .digit(digit),
        .valid(valid), .cancel(cancel), .blank(blank), .finish(finish), .swap(swap),
        .state(state), .vote_status(vote_status), .entry_bcd(entry_bcd),
        .res_sel(res_sel), .res_count(res_count), .counts(counts), .sat(sat)
    );

    urna_tally_n #(.CNT_W(3)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .digit(digit),
        .valid(valid), .cancel(cancel), .blank(blank), .finish(finish), .swap(swap),
        .state(state_s), .vote_status(vote_status_s), .entry_bcd(entry_bcd_s),
        .res_sel(res_sel_s), .res_count(res_count_s), .counts(counts_s), .sat(sat_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic press(input logic [3:0] k);
        {valid, cancel, blank, finish} = k;
        tick();
        {valid, cancel, blank, finish} = 4'b0000;
        tick();
    endtask

    task automatic key_digit(input logic [3:0] d);
        digit = d;
        press(K_V);
    endtask

    task automatic vote(input logic [3:0] d0, input logic [3:0] d1);
        key_digit(d0);
        key_digit(d1);
        press(K_V);
    endtask

    task automatic open_election();
        start = 1'b1;
        press(K_V);
        start = 1'b0;
    endtask

    function automatic logic [7:0] c8(input int i);
        return counts[8*i +: 8];
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        {start, valid, cancel, blank, finish, swap} = '0;
        digit = 4'd0;
        tick(); tick();

        check("reset_state",  state,       32'd0);
        check("reset_status", vote_status, 32'd0);
        check("reset_entry",  entry_bcd,   32'hFF);
        check("reset_sel",    res_sel,     32'd0);
        check("reset_rcount", res_count,   32'd0);
        check("reset_counts", counts,      32'd0);
        check("reset_sat",    sat,         32'd0);

        reset_n = 1'b1;
        tick();

        // valid alone in CLOSED does not open the election
        press(K_V);
        check("closed_no_start", state, 32'd0);

        // 1: open, vote 13 -> candidate 0
        open_election();
        check("open_state", state, 32'd1);
        key_digit(4'd1);
        check("first_digit_ms", entry_bcd, 32'h1F);
        key_digit(4'd3);
        check("confirm_state", state, 32'd2);
        check("confirm_entry", entry_bcd, 32'h13);
        press(K_V);
        check("v13_c0",     c8(0),       32'd1);
        check("v13_status", vote_status, 32'd1);
        check("v13_entry",  entry_bcd,   32'hFF);
        check("v13_state",  state,       32'd1);

        // 2: unknown code 91 -> null; blank with empty entry -> blank
        vote(4'd9, 4'd1);
        check("v91_null",   c8(2),       32'd1);
        check("v91_status", vote_status, 32'd2);
        press(K_B);
        check("blank_cnt",    c8(3),       32'd1);
        check("blank_status", vote_status, 32'd3);

        // 3: code 22 attributed to candidate 0 under swap, candidate 1 otherwise
        swap = 1'b1;
        vote(4'd2, 4'd2);
        check("swap_c0", c8(0), 32'd2);
        check("swap_c1", c8(1), 32'd0);
        swap = 1'b0;
        vote(4'd2, 4'd2);
        check("noswap_c1", c8(1), 32'd1);
        check("noswap_c0", c8(0), 32'd2);

        // 4: cancel clears a partial entry; out-of-range digit ignored
        key_digit(4'd2);
        press(K_C);
        check("cancel_entry", entry_bcd, 32'hFF);
        vote(4'd1, 4'd3);
        check("after_cancel_c0", c8(0), 32'd3);
        check("after_cancel_c1", c8(1), 32'd1);
        key_digit(4'd12);
        check("digit12_entry", entry_bcd, 32'hFF);
        check("digit12_state", state,     32'd1);

        // blank with a digit already entered is ignored
        key_digit(4'd5);
        press(K_B);
        check("blank_partial_cnt",   c8(3),     32'd1);
        check("blank_partial_entry", entry_bcd, 32'h5F);
        press(K_C);

        // 5: held valid stores one digit; valid+cancel on one edge -> cancel only
        digit = 4'd1;
        valid = 1'b1;
        repeat (5) tick();
        valid = 1'b0;
        tick();
        check("held_valid_entry", entry_bcd, 32'h1F);
        check("held_valid_state", state,     32'd1);
        digit = 4'd3;
        press(K_V | K_C);
        check("vc_entry", entry_bcd, 32'hFF);
        check("vc_state", state,     32'd1);

        // start in ENTRY is ignored: digit taken, counters untouched
        start = 1'b1;
        key_digit(4'd4);
        start = 1'b0;
        check("start_entry_digit", entry_bcd, 32'h4F);
        check("start_entry_c0",    c8(0),     32'd3);
        press(K_C);

        // 6: results readout c0=3 c1=1 null=1 blank=1
        press(K_F);
        check("res_state", state,     32'd3);
        check("res_sel0",  res_sel,   32'd0);
        check("res_cnt0",  res_count, 32'd3);
        press(K_F);
        check("res_sel1",  res_sel,   32'd1);
        check("res_cnt1",  res_count, 32'd1);
        press(K_F);
        check("res_sel2",  res_sel,   32'd2);
        check("res_cnt2",  res_count, 32'd1);
        press(K_F);
        check("res_sel3",  res_sel,   32'd3);
        check("res_cnt3",  res_count, 32'd1);
        press(K_F);
        check("res_wrap_state", state,     32'd0);
        check("res_wrap_sel",   res_sel,   32'd0);
        check("res_closed_cnt", res_count, 32'd0);
        check("closed_keeps_c0", c8(0),    32'd3);

        // saturation: 9 votes into 3-bit counters stops at 7 and sets sat
        open_election();
        check("reopen_counts", counts, 32'd0);
        check("reopen_status", vote_status, 32'd0);
        for (int v = 0; v < 9; v++) vote(4'd1, 4'd3);
        check("sat8_c0",  c8(0),          32'd9);
        check("sat8_flag", sat,           32'd0);
        check("sat3_c0",  counts_s[2:0],  32'd7);
        check("sat3_flag", sat_s,         32'd1);
        check("sat3_status", vote_status_s, 32'd1);

        // new election straight from RESULTS clears counters and sat
        press(K_F);
        check("res2_state", state, 32'd3);
        open_election();
        check("res_restart_state", state,    32'd1);
        check("res_restart_counts", counts_s, 32'd0);
        check("res_restart_sat",   sat_s,    32'd0);

        // 7: async reset mid-vote
        vote(4'd2, 4'd2);
        key_digit(4'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_state",  state,       32'd0);
        check("midrst_entry",  entry_bcd,   32'hFF);
        check("midrst_counts", counts,      32'd0);
        check("midrst_status", vote_status, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        open_election();
        check("post_rst_state",  state,  32'd1);
        check("post_rst_counts", counts, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
